tbird_sequencer: RTL and testbench



---
 rtl/tbird_sequencer.sv | 132 +++++++++++++
 tb/tb_tbird_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tbird_sequencer.sv
// Tail-light sequencer: prescaled step tick drives LAMPS-wide thermometer sweeps (left/right/hazard).
// Optional steady brake light on undriven sides is enabled with `define BRAKE_EN.
module tbird_sequencer #(
    parameter int TICK_DIV = 3000000,
    parameter int LAMPS    = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             left_in,
    input  logic             right_in,
    input  logic             hazard_in,
`ifdef BRAKE_EN
    input  logic             brake_in,
`endif
    output logic [LAMPS-1:0] left_out,
    output logic [LAMPS-1:0] right_out,
    output logic             busy_out,
    output logic             tick_out
);
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int STEP_W = $clog2(LAMPS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LEFT   = 2'd1;
    localparam logic [1:0] S_RIGHT  = 2'd2;
    localparam logic [1:0] S_HAZARD = 2'd3;

`ifdef BRAKE_EN
    localparam int NREQ = 4;
    logic [NREQ-1:0] req_pins;
    assign req_pins = {brake_in, hazard_in, right_in, left_in};
`else
    localparam int NREQ = 3;
    logic [NREQ-1:0] req_pins;
    assign req_pins = {hazard_in, right_in, left_in};
`endif

    logic [NREQ-1:0]   sync1_q, sync2_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [1:0]        state_q, state_d, req_mode;
    logic [STEP_W-1:0] step_q, step_d;
    logic [LAMPS-1:0]  left_q, left_d, right_q, right_d, therm, idle_fill;
    logic              busy_q, busy_d;

    function automatic logic [LAMPS-1:0] therm_f(input logic [STEP_W-1:0] s);
        logic [LAMPS-1:0] t;
        t = '0;
        for (int i = 0; i < LAMPS; i++) t[i] = (STEP_W'(i) < s);
        return t;
    endfunction

    always_comb begin
        req_mode = S_IDLE;
        if (sync2_q[2] || (sync2_q[0] && sync2_q[1])) req_mode = S_HAZARD;
        else if (sync2_q[0])                          req_mode = S_LEFT;
        else if (sync2_q[1])                          req_mode = S_RIGHT;
    end

    always_comb begin
        cnt_d  = (cnt_q == CNT_W'(TICK_DIV - 1)) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_d == CNT_W'(TICK_DIV - 1));
    end

    // Mode is only re-sampled at IDLE or at the wrap step, so sweeps never truncate.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (tick_q) begin
            if (state_q == S_IDLE) begin
                state_d = req_mode;
                step_d  = '0;
            end else if (step_q != STEP_W'(LAMPS)) begin
                step_d = step_q + 1'b1;
            end else begin
                step_d  = '0;
                state_d = req_mode;
            end
        end
    end

    // Lamps follow the next state every cycle so a brake change shows without waiting for a tick.
    always_comb begin
        therm = therm_f(step_d);
`ifdef BRAKE_EN
        idle_fill = sync2_q[3] ? '1 : '0;
`else
        idle_fill = '0;
`endif
        left_d  = idle_fill;
        right_d = idle_fill;
        case (state_d)
            S_LEFT:   left_d  = therm;
            S_RIGHT:  right_d = therm;
            S_HAZARD: begin
                left_d  = therm;
                right_d = therm;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            state_q <= S_IDLE;
            step_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= req_pins;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            step_q  <= step_d;
            left_q  <= left_d;
            right_q <= right_d;
            busy_q  <= busy_d;
        end
    end

    assign left_out  = left_q;
    assign right_out = right_q;
    assign busy_out  = busy_q;
    assign tick_out  = tick_q;
endmodule

// File: tb/tb_tbird_sequencer.sv
// Bench for tbird_sequencer: directed scenarios plus randomized requests against a sweep-level model.
module tb_tbird_sequencer;
    localparam int TD = 4;
    localparam int L  = 3;
    localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HAZ = 3;

    logic clk_in = 1'b0, rst_in = 1'b1;
    logic left_in = 1'b0, right_in = 1'b0, hazard_in = 1'b0, brake_in = 1'b0;
    logic [L-1:0] left_out, right_out;
    logic busy_out, tick_out;

    int checks = 0;
    int errors = 0;

    tbird_sequencer #(.TICK_DIV(TD), .LAMPS(L)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .left_in(left_in), .right_in(right_in), .hazard_in(hazard_in),
`ifdef BRAKE_EN
        .brake_in(brake_in),
`endif
        .left_out(left_out), .right_out(right_out),
        .busy_out(busy_out), .tick_out(tick_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sweep-level model: edges since reset, pin history two edges deep, current mode and lamp count.
    int k, m_mode, m_pos;
    bit m_brake;
    logic [3:0] p1, p2;

    function automatic int decode(input logic [3:0] r);
        if (r[2] || (r[0] && r[1])) return M_HAZ;
        if (r[0]) return M_LEFT;
        if (r[1]) return M_RIGHT;
        return M_IDLE;
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            k = 0; m_mode = M_IDLE; m_pos = 0; m_brake = 0; p1 = '0; p2 = '0;
        end else begin
            if (k % TD == TD - 1) begin
                if (m_mode == M_IDLE) begin
                    m_mode = decode(p2); m_pos = 0;
                end else if (m_pos < L) begin
                    m_pos++;
                end else begin
                    m_pos = 0; m_mode = decode(p2);
                end
            end
`ifdef BRAKE_EN
            m_brake = p2[3];
`endif
            k++;
            p2 = p1;
            p1 = {brake_in, hazard_in, right_in, left_in};
        end
    end

    function automatic logic [L-1:0] side_exp(input bit driven, input bit brk, input int pos);
        if (driven) return L'((1 << pos) - 1);
        return brk ? {L{1'b1}} : {L{1'b0}};
    endfunction

    always @(negedge clk_in) begin
        check("tick", tick_out, (k % TD == TD - 1));
        check("busy", busy_out, (m_mode != M_IDLE));
        check("left", left_out, side_exp(m_mode == M_LEFT || m_mode == M_HAZ, m_brake, m_pos));
        check("right", right_out, side_exp(m_mode == M_RIGHT || m_mode == M_HAZ, m_brake, m_pos));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_lamp(input bit right_side, input logic [L-1:0] val, input int bound,
                             input string name, output int n);
        n = 0;
        while (((right_side ? right_out : left_out) !== val) && n < bound) begin
            @(negedge clk_in);
            n++;
        end
        check(name, ((right_side ? right_out : left_out) === val), 1);
    endtask

    int n, tick_seen;

    initial begin
        @(negedge clk_in);
        check("rst_left", left_out, 0);
        check("rst_busy", busy_out, 0);
        rst_in = 1'b0;

        // Idle for 40 cycles: count ticks, expect one per TD cycles.
        tick_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (tick_out) tick_seen++;
        end
        check("idle_tick_count", tick_seen, 10);
        check("idle_right", right_out, 0);

        // Right turn held.
        right_in = 1'b1;
        wait_lamp(1, 3'b001, 20, "right_first", n);
        check("first_lamp_latency_ok", (n <= 10), 1);
        cyc(4); check("right_s2", right_out, 3'b011); check("right_left0", left_out, 0);
        cyc(4); check("right_s3", right_out, 3'b111);
        cyc(4); check("right_wrap", right_out, 3'b000); check("right_busy", busy_out, 1);
        cyc(4); check("right_s1b", right_out, 3'b001);

        // Reset mid-sweep blanks outputs before any clock edge.
        wait_lamp(1, 3'b011, 20, "right_at_011", n);
        #2 rst_in = 1'b1;
        #1 check("async_rst_right", right_out, 0);
        check("async_rst_busy", busy_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        cyc(12);
        right_in = 1'b0;
        cyc(30);

        // Hazard, then drop left at step 1.
        left_in = 1'b1; right_in = 1'b1;
        wait_lamp(1, 3'b001, 20, "haz_first", n);
        check("haz_left_s1", left_out, 3'b001);
        left_in = 1'b0;
        cyc(4); check("haz_l_s2", left_out, 3'b011); check("haz_r_s2", right_out, 3'b011);
        cyc(4); check("haz_l_s3", left_out, 3'b111); check("haz_r_s3", right_out, 3'b111);
        cyc(4); check("haz_wrap_l", left_out, 0); check("haz_wrap_r", right_out, 0);
        cyc(4); check("to_right_l", left_out, 0); check("to_right_r", right_out, 3'b001);
        right_in = 1'b0;
        cyc(30);

        // Left pulse for one tick period gives exactly one sweep.
        left_in = 1'b1;
        cyc(4);
        left_in = 1'b0;
        wait_lamp(0, 3'b001, 20, "pulse_first", n);
        cyc(4); check("pulse_s2", left_out, 3'b011);
        cyc(4); check("pulse_s3", left_out, 3'b111); check("pulse_busy_hold", busy_out, 1);
        cyc(4); check("pulse_end", left_out, 0); check("pulse_busy_fall", busy_out, 0);
        cyc(8);

`ifdef BRAKE_EN
        brake_in = 1'b1; left_in = 1'b1;
        wait_lamp(0, 3'b001, 20, "brake_left_first", n);
        check("brake_right_on", right_out, 3'b111);
        cyc(4); check("brake_left_s2", left_out, 3'b011); check("brake_right_on2", right_out, 3'b111);
        hazard_in = 1'b1;
        cyc(16);
        hazard_in = 1'b0; left_in = 1'b0; brake_in = 1'b0;
        cyc(30);
`endif

        // Randomized requests, with occasional asynchronous resets.
        for (int it = 0; it < 120; it++) begin
            left_in   = 1'($urandom_range(0, 1));
            right_in  = 1'($urandom_range(0, 1));
            hazard_in = ($urandom_range(0, 5) == 0);
`ifdef BRAKE_EN
            brake_in  = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 24) == 0) begin
                #2 rst_in = 1'b1;
                @(negedge clk_in);
                rst_in = 1'b0;
            end
            cyc($urandom_range(1, 14));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
